// File: rtl/uart_tx_ctl.sv
// UART transmit controller: 8N1/8E1/8O1 (one or two stop bits) framing,
// paced by a 16x baud enable, with a valid/ready byte input.
module uart_tx_ctl #(
    parameter int STOP_BITS = 1,
    parameter int PARITY    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_x16_en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0] r_state;
    logic [3:0] r_cnt;
    logic [2:0] r_idx;
    logic [7:0] r_shift;
    logic       r_stop;
    logic       r_txd;
    logic       r_busy;

    logic       w_accept;
    logic       w_bit_end;
    logic       w_par;
    logic [2:0] w_idx_nxt;

    assign tx_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept  = tx_valid && tx_ready;
    assign w_bit_end = baud_x16_en && (r_cnt == 4'd15);
    assign w_idx_nxt = r_idx + 3'd1;
    // Parity comes from the captured byte, never from live tx_data
    assign w_par     = (PARITY == 2) ? ~(^r_shift) : (^r_shift);

    assign txd     = r_txd;
    assign tx_busy = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
            r_stop  <= 1'b0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            if (r_state != S_IDLE && baud_x16_en)
                r_cnt <= r_cnt + 4'd1;
            case (r_state)
                S_IDLE: begin
                    r_txd  <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_accept) begin
                        r_shift <= tx_data;
                        r_state <= S_START;
                        r_txd   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= 4'd0;
                        r_idx   <= 3'd0;
                        r_stop  <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_idx   <= 3'd0;
                        r_txd   <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_idx == 3'd7) begin
                            if (PARITY != 0) begin
                                r_state <= S_PARITY;
                                r_txd   <= w_par;
                            end else begin
                                r_state <= S_STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_idx <= w_idx_nxt;
                            r_txd <= r_shift[w_idx_nxt];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
                    end
                end
                S_STOP: begin
                    r_txd <= 1'b1;
                    if (w_bit_end) begin
                        if (STOP_BITS == 2 && !r_stop) begin
                            r_stop <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule
